// File: rtl/word_game_pkg.sv
// Shared types and helpers for the word-game timer blocks: state encoding,
// BCD limits and a BCD conversion helper for decimal parameters.
package word_game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam logic [7:0] BCD_MAX = 8'h99;

  // Two-digit BCD image of a small decimal value (0..99).
  function automatic logic [7:0] to_bcd2(input int unsigned value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((value / 10) % 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD counter with load, saturating increment and decrement that
// stops at zero. Priority: Reset/clear > load > inc > dec.
module bcd_counter2
  import word_game_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       inc,
  input  logic       dec,
  output logic [7:0] value
);

  logic [7:0] value_q;
  logic [7:0] inc_value;
  logic [7:0] dec_value;

  always_comb begin
    inc_value = value_q;
    if (value_q != BCD_MAX) begin
      if (value_q[3:0] == 4'd9) inc_value = {value_q[7:4] + 4'd1, 4'd0};
      else                      inc_value = {value_q[7:4], value_q[3:0] + 4'd1};
    end
  end

  // Borrow from the tens digit so 10 steps down to 09, never 0F.
  always_comb begin
    dec_value = value_q;
    if (value_q != 8'h00) begin
      if (value_q[3:0] == 4'd0) dec_value = {value_q[7:4] - 4'd1, 4'd9};
      else                      dec_value = {value_q[7:4], value_q[3:0] - 4'd1};
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset || clear) value_q <= 8'h00;
    else if (load)      value_q <= load_value;
    else if (inc)       value_q <= inc_value;
    else if (dec)       value_q <= dec_value;
  end

  assign value = value_q;

endmodule

// File: rtl/word_round_timer.sv
// Per-word countdown timer and BCD score accumulator for the word game.
// Optional best-score tracking is built when WORD_TIMER_HIGH_SCORE_EN is defined.
module word_round_timer
  import word_game_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50000000,
  parameter int unsigned ROUND_SECONDS = 10
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Enable,
  input  logic       Submit,
  input  logic       InScore,
  output logic       TimeOut,
  output logic       Running,
  output logic [7:0] SecondsLeft,
  output logic [7:0] Score,
  output logic [7:0] HighScore
);

  localparam int unsigned   PW        = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]    ROUND_BCD = to_bcd2(ROUND_SECONDS);

  state_e        state_q;
  logic [PW-1:0] prescaler_q;
  logic          timeout_q;
  logic          running_q;
  logic          inscore_q;
  logic          tick;
  logic          sec_load;
  logic          sec_dec;
  logic          score_inc;

  assign tick      = (state_q == RUN) && (prescaler_q == PRE_LAST);
  assign sec_load  = Start && Enable;
  // Submit freezes the countdown even on the tick cycle.
  assign sec_dec   = Start && !Enable && !Submit && tick;
  assign score_inc = InScore && !inscore_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      timeout_q   <= 1'b0;
      running_q   <= 1'b0;
    end else if (!Start) begin
      state_q     <= IDLE;
      prescaler_q <= '0;
      timeout_q   <= 1'b0;
      running_q   <= 1'b0;
    end else if (Enable) begin
      state_q     <= RUN;
      prescaler_q <= '0;
      timeout_q   <= 1'b0;
      running_q   <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (Submit) begin
            state_q   <= HOLD;
            running_q <= 1'b0;
          end else if (tick) begin
            prescaler_q <= '0;
            if (SecondsLeft == 8'h01) begin
              state_q   <= EXPIRED;
              timeout_q <= 1'b1;
              running_q <= 1'b0;
            end
          end else begin
            prescaler_q <= prescaler_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) inscore_q <= 1'b0;
    else       inscore_q <= InScore;
  end

  bcd_counter2 u_seconds (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear      (!Start),
    .load       (sec_load),
    .load_value (ROUND_BCD),
    .inc        (1'b0),
    .dec        (sec_dec),
    .value      (SecondsLeft)
  );

  bcd_counter2 u_score (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear      (!Start),
    .load       (1'b0),
    .load_value (8'h00),
    .inc        (score_inc),
    .dec        (1'b0),
    .value      (Score)
  );

`ifdef WORD_TIMER_HIGH_SCORE_EN
  logic       start_q;
  logic [7:0] high_q;

  // BCD compares correctly as plain binary since each digit is monotonic.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      start_q <= 1'b0;
      high_q  <= 8'h00;
    end else begin
      start_q <= Start;
      if (start_q && !Start && (Score > high_q)) high_q <= Score;
    end
  end

  assign HighScore = high_q;
`else
  assign HighScore = 8'h00;
`endif

  assign TimeOut = timeout_q;
  assign Running = running_q;

endmodule

// File: tb/tb_word_round_timer.sv
// Randomised self-checking bench for word_round_timer: two instances (3 s and 12 s rounds)
// checked every cycle against an integer-arithmetic model of the game rules.
module tb_word_round_timer;

  localparam int unsigned T = 4;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Start = 1'b0;
  logic Enable = 1'b0;
  logic Submit = 1'b0;
  logic InScore = 1'b0;

  logic       to_a, run_a, to_b, run_b;
  logic [7:0] sec_a, score_a, high_a, sec_b, score_b, high_b;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 Clock = ~Clock;

  word_round_timer #(.TICKS_PER_SEC(T), .ROUND_SECONDS(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Enable(Enable), .Submit(Submit),
    .InScore(InScore), .TimeOut(to_a), .Running(run_a), .SecondsLeft(sec_a),
    .Score(score_a), .HighScore(high_a)
  );

  word_round_timer #(.TICKS_PER_SEC(T), .ROUND_SECONDS(12)) dut12 (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Enable(Enable), .Submit(Submit),
    .InScore(InScore), .TimeOut(to_b), .Running(run_b), .SecondsLeft(sec_b),
    .Score(score_b), .HighScore(high_b)
  );

  // Model: 0 idle, 1 counting, 2 held, 3 expired; seconds and score as integers.
  int  m_mode[2];
  int  m_secs[2];
  int  m_phase[2];
  bit  m_to[2];
  int  m_score[2];
  int  m_high[2];
  bit  m_prev_in[2];
  bit  m_prev_start[2];
  int  m_round[2] = '{3, 12};

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input int i);
    if (Reset) begin
      m_mode[i] = 0; m_secs[i] = 0; m_phase[i] = 0; m_to[i] = 0;
      m_score[i] = 0; m_high[i] = 0; m_prev_in[i] = 0; m_prev_start[i] = 0;
      return;
    end
`ifdef WORD_TIMER_HIGH_SCORE_EN
    if (m_prev_start[i] && !Start && m_score[i] > m_high[i]) m_high[i] = m_score[i];
`endif
    m_prev_start[i] = Start;
    if (!Start) begin
      m_mode[i] = 0; m_secs[i] = 0; m_phase[i] = 0; m_to[i] = 0; m_score[i] = 0;
    end else begin
      if (InScore && !m_prev_in[i] && m_score[i] < 99) m_score[i]++;
      if (Enable) begin
        m_mode[i] = 1; m_secs[i] = m_round[i]; m_phase[i] = 0; m_to[i] = 0;
      end else if (m_mode[i] == 1) begin
        if (Submit) m_mode[i] = 2;
        else begin
          m_phase[i]++;
          if (m_phase[i] == T) begin
            m_phase[i] = 0;
            m_secs[i]--;
            if (m_secs[i] == 0) begin
              m_mode[i] = 3;
              m_to[i] = 1;
            end
          end
        end
      end
    end
    m_prev_in[i] = InScore;
  endtask

  always @(posedge Clock) begin
    model_step(0);
    model_step(1);
    if (Reset) chk_en = 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge Clock) begin
    if (chk_en) begin
      chk("a.TimeOut", {7'd0, to_a}, {7'd0, m_to[0]});
      chk("a.Running", {7'd0, run_a}, {7'd0, m_mode[0] == 1});
      chk("a.SecondsLeft", sec_a, bcd(m_secs[0]));
      chk("a.Score", score_a, bcd(m_score[0]));
      chk("a.HighScore", high_a, bcd(m_high[0]));
      chk("b.TimeOut", {7'd0, to_b}, {7'd0, m_to[1]});
      chk("b.Running", {7'd0, run_b}, {7'd0, m_mode[1] == 1});
      chk("b.SecondsLeft", sec_b, bcd(m_secs[1]));
      chk("b.Score", score_b, bcd(m_score[1]));
      chk("b.HighScore", high_b, bcd(m_high[1]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic pulse_enable();
    Enable = 1'b1;
    cyc(1);
    Enable = 1'b0;
  endtask

  task automatic score_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      InScore = 1'b1; cyc(1);
      InScore = 1'b0; cyc(1);
    end
  endtask

  logic [7:0] exp_high;

  initial begin
    cyc(2);
    Reset = 1'b0; Start = 1'b1;
    cyc(1);
    chk("lit.reset_secs", sec_a, 8'h00);
    chk("lit.reset_run", {7'd0, run_a}, 8'h00);
    chk("lit.reset_score", score_a, 8'h00);

    // Basic round: 3 s at 4 ticks/s.
    pulse_enable();
    chk("lit.load3", sec_a, 8'h03);
    chk("lit.load12", sec_b, 8'h12);
    chk("lit.running", {7'd0, run_a}, 8'h01);
    cyc(3);
    chk("lit.not_yet", sec_a, 8'h03);
    cyc(1);
    chk("lit.sec02", sec_a, 8'h02);
    chk("lit.sec11", sec_b, 8'h11);
    cyc(4);
    chk("lit.sec01", sec_a, 8'h01);
    chk("lit.sec10", sec_b, 8'h10);
    chk("lit.model10", bcd(m_secs[1]), 8'h10);
    cyc(3);
    chk("lit.pre_timeout", {7'd0, to_a}, 8'h00);
    cyc(1);
    chk("lit.timeout", {7'd0, to_a}, 8'h01);
    chk("lit.sec00", sec_a, 8'h00);
    chk("lit.sec09", sec_b, 8'h09);
    chk("lit.model09", bcd(m_secs[1]), 8'h09);
    cyc(5);
    chk("lit.timeout_held", {7'd0, to_a}, 8'h01);

    // Submit at +5 freezes at 02.
    pulse_enable();
    chk("lit.to_cleared", {7'd0, to_a}, 8'h00);
    cyc(4);
    Submit = 1'b1; cyc(1); Submit = 1'b0;
    chk("lit.hold_secs", sec_a, 8'h02);
    cyc(20);
    chk("lit.hold_secs20", sec_a, 8'h02);
    chk("lit.hold_run", {7'd0, run_a}, 8'h00);
    chk("lit.hold_to", {7'd0, to_a}, 8'h00);
    pulse_enable();
    chk("lit.reload", sec_a, 8'h03);

    // Enable and Submit together.
    Submit = 1'b1; Enable = 1'b1; cyc(1); Submit = 1'b0; Enable = 1'b0;
    chk("lit.en_sub_run", {7'd0, run_a}, 8'h01);

    // Held InScore counts once, then saturation.
    InScore = 1'b1; cyc(5); InScore = 1'b0; cyc(1);
    chk("lit.held_once", score_a, 8'h01);
    score_pulses(100);
    chk("lit.saturate", score_a, 8'h99);

    // Best-score tracking across two games.
`ifdef WORD_TIMER_HIGH_SCORE_EN
    exp_high = 8'h07;
`else
    exp_high = 8'h00;
`endif
    Reset = 1'b1; cyc(1); Reset = 1'b0;
    score_pulses(7);
    chk("lit.score7", score_a, 8'h07);
    Start = 1'b0; cyc(1);
    chk("lit.score_clr", score_a, 8'h00);
    chk("lit.high7", high_a, exp_high);
    Start = 1'b1;
    score_pulses(4);
    Start = 1'b0; cyc(1);
    chk("lit.high_kept", high_a, exp_high);
    Start = 1'b1; cyc(1);

    // Random phase.
    for (int n = 0; n < 4000; n++) begin
      Reset   = ($urandom_range(0, 999) == 0);
      Start   = ($urandom_range(0, 79) != 0);
      Enable  = ($urandom_range(0, 39) == 0);
      Submit  = ($urandom_range(0, 29) == 0);
      InScore = ($urandom_range(0, 2) == 0);
      cyc(1);
    end
    Reset = 1'b0; Start = 1'b1; Enable = 1'b0; Submit = 1'b0; InScore = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
